fp16_mul_arbiter: RTL and testbench
===================================

FP16_MUL_ARBITER -- requirements
Module: fp16_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FP16 multiplier; legal values are 2 to 8.
REQ-002 Parameter ID_W, default 2: width of the requester index, equal to clog2(NUM_REQ).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-006 Port req_a, input, 16*NUM_REQ bits: FP16 operand A; requester i uses bits [16i+15:16i].
REQ-007 Port req_b, input, 16*NUM_REQ bits: FP16 operand B, packed the same way as req_a.
REQ-008 Port req_ready, output, NUM_REQ bits: one-hot grant/accept.
REQ-009 Port mul_a, output, 16 bits: registered operand A to the shared combinational FP16 multiplier.
REQ-010 Port mul_b, output, 16 bits: registered operand B to the shared combinational FP16 multiplier.
REQ-011 Port mul_result, input, 16 bits: combinational product from the multiplier.
REQ-012 Port rsp_valid, output, 1 bit: response valid.
REQ-013 Port rsp_ready, input, 1 bit: response consumer ready.
REQ-014 Port rsp_id, output, ID_W bits: index of the requester that owns the response.
REQ-015 Port rsp_result, output, 16 bits: registered FP16 product.
REQ-016 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-018 In IDLE, req_ready SHALL be the combinational one-hot round-robin grant over req_valid; it SHALL be all zeros in every other state and whenever req_valid is zero.
REQ-019 Round-robin SHALL search from index (last_grant+1) mod NUM_REQ upward with wrap-around; last_grant SHALL update only on an accepted request.
REQ-020 A request SHALL be accepted when req_valid[i] and req_ready[i] are both high at a clock edge; in that cycle, mul_a, mul_b and the captured id SHALL load from requester i, and the state SHALL go to EXEC.
REQ-021 In EXEC, rsp_result SHALL capture mul_result, rsp_id SHALL take the captured id, and rsp_valid SHALL be set; the state SHALL go to RESP, and EXEC SHALL last exactly one cycle.
REQ-022 Latency SHALL be: accept at edge T, then rsp_valid high after edge T+1, which is the first cycle a response can transfer.
REQ-023 In RESP, rsp_valid, rsp_id and rsp_result SHALL remain stable until rsp_valid and rsp_ready are both high at an edge; after that edge, rsp_valid SHALL clear and the state SHALL return to IDLE.
REQ-024 Minimum issue interval SHALL be 3 cycles; no new grant SHALL occur in the cycle of the response handshake.
REQ-025 mul_a and mul_b SHALL hold their values outside the accept edge, so that mul_result stays stable through EXEC and RESP.
REQ-026 A requester SHALL hold req_valid, req_a and req_b stable until it is granted; the block SHALL NOT check this rule.
REQ-027 Dropping req_valid before grant SHALL simply remove that requester from arbitration without side effects.
REQ-028 The block SHALL NOT interpret the FP16 data; NaN, infinity, zero and subnormal values SHALL pass through bit-exact.

Reset
REQ-029 While rst_n is low, the block SHALL set state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0x0000, mul_a=0x0000, mul_b=0x0000 and busy=0.
REQ-030 Reset SHALL set last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-031 Reset asserted in any state, including mid-EXEC or mid-RESP, SHALL abort the in-flight operation with no response issued.
REQ-032 After release, the first grant SHALL be possible in the first cycle with rst_n high.

Verification
REQ-033 The bench SHALL run a single request: req_valid=0001, a=0x3C00, b=0x4000, rsp_ready=1 -> req_ready=0001 in the accept cycle, then after 2 edges rsp_valid=1, rsp_id=0, rsp_result=0x4000.
REQ-034 The bench SHALL run full contention: req_valid=1111 held continuously -> grant order 0,1,2,3,0, with each grant 3 cycles apart when rsp_ready=1.
REQ-035 The bench SHALL apply backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_valid, rsp_id and rsp_result stay stable, req_ready=0000 and busy=1; raising rsp_ready completes one transfer, then the block returns to IDLE.
REQ-036 The bench SHALL check special-value pass-through: requester 2 sends a=0x7C00, b=0x0000 -> rsp_result=0x7E00, rsp_id=2.
REQ-037 The bench SHALL reset mid-RESP: drive rst_n low while rsp_valid=1 -> rsp_valid=0 and busy=0 immediately, without waiting for a clock edge; after release with req_valid=1010, requester 1 is granted first.
REQ-038 The bench SHALL check the round-robin skip: last_grant=1 with req_valid=0011 -> requester 0 is granted next, not requester 1.

Source files
------------

// File: rtl/fp16_mul_arbiter.sv
// rtl/fp16_mul_arbiter.sv - round-robin arbiter sharing one external FP16 multiplier
// Operands are registered on accept, the product is registered one cycle later and held until taken.
module fp16_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [15:0]           mul_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_result,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [15:0]        sel_a;
  logic [15:0]        sel_b;
  logic [ID_W:0]      rr_sum;
  logic [ID_W-1:0]    rr_idx;

  // Search starts one past the previous winner and wraps modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = last_grant;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant} + (ID_W+1)'(k);
      if (rr_sum >= (ID_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[ID_W-1:0];
      if (!grant_any && req_valid[rr_idx]) begin
        grant_any = 1'b1;
        grant_id  = rr_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = |(req_valid & req_ready);
  assign busy   = (state != IDLE);

  // last_grant only moves on accept, so it doubles as the in-flight requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a      <= 16'h0000;
      mul_b      <= 16'h0000;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= 16'h0000;
    end else begin
      if (accept) begin
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_result <= mul_result;
        rsp_id     <= last_grant;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb/tb_fp16_mul_arbiter.sv - directed scoreboard bench for fp16_mul_arbiter
// Each tick compares grant, busy and response against a phase model and a response queue.
module tb_fp16_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ph     = 0;
  int last_g = 3;
  logic [15:0] cur_a;
  logic [15:0] cur_b;
  logic [17:0] sb[$];
  int          glog[$];
  int          gcyc[$];

  always #5 clk = ~clk;

  fp16_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy)
  );

  // Truncating FP16 multiply; subnormals flush to zero, invalid results give canonical NaN.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          ea, eb, e;
    logic [21:0] p;
    logic [9:0]  m;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return 16'h7E00;
    if ((ea == 31 && b[14:0] == 0) || (eb == 31 && a[14:0] == 0)) return 16'h7E00;
    if (ea == 31 || eb == 31) return {s, 5'h1F, 10'h000};
    if (ea == 0 || eb == 0) return {s, 15'h0000};
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = ea + eb - 15;
    if (p[21]) begin
      e = e + 1;
      m = p[20:11];
    end else begin
      m = p[19:10];
    end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    return {s, 5'(e), m};
  endfunction

  assign mul_result = fmul(mul_a, mul_b);

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic tick();
    int         p;
    logic [3:0] eg;
    @(negedge clk);
    cyc++;
    p  = (ph == 0) ? rr_pick(req_valid, last_g) : -1;
    eg = (p >= 0) ? 4'(1 << p) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(ph == 2));
    if (ph != 0) begin
      chk("mul_a_hold", 32'(mul_a), 32'(cur_a));
      chk("mul_b_hold", 32'(mul_b), 32'(cur_b));
    end
    if ((req_valid & req_ready) != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (req_ready[i]) glog.push_back(i);
      gcyc.push_back(cyc);
    end
    if (ph == 2) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("rsp_id_result", 32'({rsp_id, rsp_result}), 32'(sb[0]));
      if (rsp_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        ph = 0;
      end
    end else if (ph == 1) begin
      ph = 2;
    end else if (p >= 0) begin
      cur_a  = req_a[16*p +: 16];
      cur_b  = req_b[16*p +: 16];
      sb.push_back({2'(p), fmul(cur_a, cur_b)});
      last_g = p;
      ph     = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (ph != 0 || sb.size() != 0); k++) tick();
    chk("drained", 32'(ph == 0 && sb.size() == 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0000);
    chk("rst_mul_a", 32'(mul_a), 32'h0000);
    chk("rst_mul_b", 32'(mul_b), 32'h0000);

    // Full contention from reset: 0,1,2,3,0, three cycles apart.
    set_req(0, 16'h3C00, 16'h4000); set_req(1, 16'h4200, 16'h3800);
    set_req(2, 16'hC000, 16'h4400); set_req(3, 16'h3555, 16'h3E00);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1 rst_n = 1'b1;
    glog.delete(); gcyc.delete();
    for (int k = 0; k < 40 && glog.size() < 5; k++) tick();
    req_valid = 4'b0000;
    chk("cont_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("cont_order", 32'(glog[i]), 32'(i % 4));
    chk("cont_first_cycle", 32'(gcyc.size() != 0 && gcyc[0] == 1), 32'd1);
    for (int i = 1; i < 5 && i < gcyc.size(); i++) chk("cont_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    drain();

    // Single request with fixed expected product.
    glog.delete();
    set_req(0, 16'h3C00, 16'h4000);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    chk("single_grant_count", 32'(glog.size()), 32'd1);
    if (glog.size() != 0) chk("single_grant_id", 32'(glog[0]), 32'd0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd0);
    chk("single_rsp_result", 32'(rsp_result), 32'h4000);
    drain();

    // Backpressure while another requester waits.
    set_req(3, 16'h4500, 16'h4100); set_req(0, 16'h3A00, 16'hBC00);
    req_valid = 4'b1000; rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0001;
    tick();
    repeat (5) tick();
    chk("bp_rsp_id", 32'(rsp_id), 32'd3);
    chk("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    drain();

    // Inf * 0 returns the canonical NaN bit-exact.
    set_req(2, 16'h7C00, 16'h0000);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("nan_rsp_result", 32'(rsp_result), 32'h7E00);
    chk("nan_rsp_id", 32'(rsp_id), 32'd2);
    drain();

    // Reset during RESP, then round-robin restarts at requester 0 priority.
    set_req(0, 16'h4400, 16'h4400); set_req(1, 16'h3800, 16'h3800);
    set_req(3, 16'h5000, 16'h0400);
    req_valid = 4'b0001; rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    sb.delete(); ph = 0; last_g = 3;
    req_valid = 4'b1010; rsp_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    glog.delete();
    tick();
    req_valid = 4'b0011;
    chk("post_reset_grant", 32'(glog.size() == 1 && glog[0] == 1), 32'd1);
    for (int k = 0; k < 10 && glog.size() < 2; k++) tick();
    req_valid = 4'b0000;
    chk("rr_skip_grant", 32'(glog.size() == 2 && glog[1] == 0), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
